// File: rtl/if_stage_pipe.sv
// if_stage_pipe: instruction-fetch stage for the 5-stage MIPS pipeline.
//
// Owns the PC and fetches over a request/response instruction-memory port with at
// most one request outstanding. Fetched words land in the IF/ID register, or in a
// one-entry skid buffer when decode is stalling. Supports stall, flush and
// branch/jump redirect, including discard of a response that is still in flight.
//
// Ports:
//   i_clk            clock, all state changes on the rising edge
//   i_rst_n          synchronous active-low reset
//   i_redirect_valid branch/jump taken this cycle (highest priority)
//   i_redirect_pc    redirect target (low alignment bits are ignored)
//   i_stall          decode cannot accept; hold IF/ID
//   i_flush          invalidate IF/ID contents
//   o_imem_req       request valid
//   o_imem_addr      request address
//   i_imem_ready     memory accepts the request this cycle
//   i_imem_rvalid    response valid
//   i_imem_rdata     fetched instruction
//   o_if_id          {pc + PC_STEP, instr}
//   o_if_id_valid    IF/ID holds a real instruction
//   o_fetch_count    instructions delivered to IF/ID (wraps)
module if_stage_pipe #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 4,
  parameter int unsigned     CNT_W    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_redirect_valid,
  input  logic [XLEN-1:0]   i_redirect_pc,
  input  logic              i_stall,
  input  logic              i_flush,
  output logic              o_imem_req,
  output logic [XLEN-1:0]   o_imem_addr,
  input  logic              i_imem_ready,
  input  logic              i_imem_rvalid,
  input  logic [XLEN-1:0]   i_imem_rdata,
  output logic [2*XLEN-1:0] o_if_id,
  output logic              o_if_id_valid,
  output logic [CNT_W-1:0]  o_fetch_count
);

  localparam logic [XLEN-1:0] Step      = XLEN'(PC_STEP);
  localparam logic [XLEN-1:0] AlignMask = ~(Step - XLEN'(1));

  typedef enum logic [1:0] {StFetch, StWait, StHold} state_e;

  state_e             r_state, w_state_d;
  logic [XLEN-1:0]    r_pc, w_pc_d;
  logic [XLEN-1:0]    r_req_pc, w_req_pc_d;
  logic               r_discard, w_discard_d;
  logic [XLEN-1:0]    r_skid, w_skid_d;
  logic [2*XLEN-1:0]  r_if_id, w_if_id_d;
  logic               r_if_id_valid, w_if_id_valid_d;
  logic [CNT_W-1:0]   r_count, w_count_d;
  logic               r_imem_req, w_imem_req_d;

  logic               w_fire;
  logic               w_free;
  logic               w_load;
  logic [XLEN-1:0]    w_load_instr;
  logic [XLEN-1:0]    w_redirect_pc;

  // r_imem_req is low for the first cycle after reset even though the state is
  // already StFetch, so the handshake must qualify on it.
  assign w_fire        = (r_state == StFetch) && r_imem_req && i_imem_ready;
  assign w_free        = !r_if_id_valid || !i_stall;
  assign w_redirect_pc = i_redirect_pc & AlignMask;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StFetch;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StFetch: begin
        if (w_fire) w_state_d = StWait;
      end
      StWait: begin
        if (i_imem_rvalid) begin
          if (i_redirect_valid || r_discard || w_free) w_state_d = StFetch;
          else                                         w_state_d = StHold;
        end
      end
      StHold: begin
        if (i_redirect_valid || !i_stall) w_state_d = StFetch;
      end
      default: w_state_d = StFetch;
    endcase
  end

  // Datapath / registered-output next values
  always_comb begin
    w_pc_d          = r_pc;
    w_req_pc_d      = r_req_pc;
    w_discard_d     = r_discard;
    w_skid_d        = r_skid;
    w_if_id_d       = r_if_id;
    w_if_id_valid_d = r_if_id_valid;
    w_count_d       = r_count;
    w_load          = 1'b0;
    w_load_instr    = r_skid;

    if (i_redirect_valid) begin
      w_pc_d = w_redirect_pc;
    end else if (w_fire) begin
      w_pc_d = r_pc + Step;
    end

    if (w_fire) w_req_pc_d = r_pc;

    unique case (r_state)
      StFetch: begin
        // Old-address request still goes out; its response must be thrown away.
        if (w_fire && i_redirect_valid) w_discard_d = 1'b1;
      end
      StWait: begin
        if (i_imem_rvalid) begin
          w_discard_d = 1'b0;
          if (!r_discard && !i_redirect_valid) begin
            if (w_free) begin
              w_load       = 1'b1;
              w_load_instr = i_imem_rdata;
            end else begin
              w_skid_d = i_imem_rdata;
            end
          end
        end else if (i_redirect_valid) begin
          w_discard_d = 1'b1;
        end
      end
      StHold: begin
        if (!i_redirect_valid && !i_stall) w_load = 1'b1;
      end
      default: ;
    endcase

    // A word reaching IF/ID in a flush cycle is dropped and not counted.
    if (w_load && !i_flush) begin
      w_if_id_d       = {r_req_pc + Step, w_load_instr};
      w_if_id_valid_d = 1'b1;
      w_count_d       = r_count + CNT_W'(1);
    end

    if (i_flush) w_if_id_valid_d = 1'b0;

    w_imem_req_d = (w_state_d == StFetch);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pc          <= RESET_PC;
      r_req_pc      <= RESET_PC;
      r_discard     <= 1'b0;
      r_skid        <= '0;
      r_if_id       <= '0;
      r_if_id_valid <= 1'b0;
      r_count       <= '0;
      r_imem_req    <= 1'b0;
    end else begin
      r_pc          <= w_pc_d;
      r_req_pc      <= w_req_pc_d;
      r_discard     <= w_discard_d;
      r_skid        <= w_skid_d;
      r_if_id       <= w_if_id_d;
      r_if_id_valid <= w_if_id_valid_d;
      r_count       <= w_count_d;
      r_imem_req    <= w_imem_req_d;
    end
  end

  // r_pc only moves on acceptance or redirect, so it doubles as the request address.
  assign o_imem_req    = r_imem_req;
  assign o_imem_addr   = r_pc;
  assign o_if_id       = r_if_id;
  assign o_if_id_valid = r_if_id_valid;
  assign o_fetch_count = r_count;

endmodule

// File: tb/tb_if_stage_pipe.sv
// Directed self-checking bench for if_stage_pipe with RESET_PC = 0x00400000.
module tb_if_stage_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [63:0] if_id;
  logic        if_id_valid;
  logic [15:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  if_stage_pipe #(
    .XLEN    (32),
    .RESET_PC(32'h0040_0000),
    .PC_STEP (4),
    .CNT_W   (16)
  ) u_dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_redirect_valid(redirect_valid),
    .i_redirect_pc   (redirect_pc),
    .i_stall         (stall),
    .i_flush         (flush),
    .o_imem_req      (imem_req),
    .o_imem_addr     (imem_addr),
    .i_imem_ready    (imem_ready),
    .i_imem_rvalid   (imem_rvalid),
    .i_imem_rdata    (imem_rdata),
    .o_if_id         (if_id),
    .o_if_id_valid   (if_id_valid),
    .o_fetch_count   (fetch_count)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From StFetch with imem_req=1 and imem_ready=1: accept, then 1-cycle response.
  task automatic fetch_one(input logic [31:0] instr);
    step();
    imem_rvalid = 1'b1;
    imem_rdata  = instr;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
  endtask

  initial begin
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0; flush = 1'b0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    step();
    step();
    check_eq("rst_req",   {63'd0, imem_req}, 64'd0);
    check_eq("rst_addr",  {32'd0, imem_addr}, 64'h0040_0000);
    check_eq("rst_if_id", if_id, 64'd0);
    check_eq("rst_valid", {63'd0, if_id_valid}, 64'd0);
    check_eq("rst_count", {48'd0, fetch_count}, 64'd0);

    // Sequential fetch
    rst_n = 1'b1; imem_ready = 1'b1;
    step();
    check_eq("seq_req0",  {63'd0, imem_req}, 64'd1);
    check_eq("seq_addr0", {32'd0, imem_addr}, 64'h0040_0000);
    step();
    check_eq("seq_wait_req", {63'd0, imem_req}, 64'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
    step();
    imem_rvalid = 1'b0;
    check_eq("seq_if_id0", if_id, 64'h0040_0004_1111_1111);
    check_eq("seq_valid0", {63'd0, if_id_valid}, 64'd1);
    check_eq("seq_addr1",  {32'd0, imem_addr}, 64'h0040_0004);
    fetch_one(32'h2222_2222);
    check_eq("seq_if_id1", if_id, 64'h0040_0008_2222_2222);
    check_eq("seq_addr2",  {32'd0, imem_addr}, 64'h0040_0008);
    fetch_one(32'h3333_3333);
    check_eq("seq_if_id2", if_id, 64'h0040_000c_3333_3333);
    check_eq("seq_count3", {48'd0, fetch_count}, 64'd3);

    // Stall: response parks in the skid buffer
    stall = 1'b1;
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'h4444_4444;
    step();
    imem_rvalid = 1'b0;
    check_eq("stall_if_id", if_id, 64'h0040_000c_3333_3333);
    check_eq("stall_req",   {63'd0, imem_req}, 64'd0);
    step();
    check_eq("hold_req",    {63'd0, imem_req}, 64'd0);
    check_eq("hold_count",  {48'd0, fetch_count}, 64'd3);
    stall = 1'b0;
    step();
    check_eq("skid_if_id",  if_id, 64'h0040_0010_4444_4444);
    check_eq("skid_count",  {48'd0, fetch_count}, 64'd4);
    check_eq("skid_addr",   {32'd0, imem_addr}, 64'h0040_0010);
    check_eq("skid_req",    {63'd0, imem_req}, 64'd1);

    // Redirect in WAIT; unaligned target is forced to alignment
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0103;
    step();
    redirect_valid = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hdead_beef;
    step();
    imem_rvalid = 1'b0;
    check_eq("rdw_count", {48'd0, fetch_count}, 64'd4);
    check_eq("rdw_if_id", if_id, 64'h0040_0010_4444_4444);
    check_eq("rdw_addr",  {32'd0, imem_addr}, 64'h0040_0100);
    check_eq("rdw_req",   {63'd0, imem_req}, 64'd1);
    fetch_one(32'h5555_5555);
    check_eq("rdw_new",   if_id, 64'h0040_0104_5555_5555);
    check_eq("rdw_cnt5",  {48'd0, fetch_count}, 64'd5);

    // Redirect + flush while in HOLD
    stall = 1'b1;
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'h6666_6666;
    step();
    imem_rvalid = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0200; flush = 1'b1;
    step();
    redirect_valid = 1'b0; flush = 1'b0; stall = 1'b0;
    check_eq("rdh_valid", {63'd0, if_id_valid}, 64'd0);
    check_eq("rdh_if_id", if_id, 64'h0040_0104_5555_5555);
    check_eq("rdh_count", {48'd0, fetch_count}, 64'd5);
    check_eq("rdh_addr",  {32'd0, imem_addr}, 64'h0040_0200);
    fetch_one(32'h7777_7777);
    check_eq("rdh_new",   if_id, 64'h0040_0204_7777_7777);
    check_eq("rdh_cnt6",  {48'd0, fetch_count}, 64'd6);

    // imem_ready low for 4 cycles
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("nrdy_req",  {63'd0, imem_req}, 64'd1);
      check_eq("nrdy_addr", {32'd0, imem_addr}, 64'h0040_0204);
    end
    imem_ready = 1'b1;
    fetch_one(32'h8888_8888);
    check_eq("nrdy_if_id", if_id, 64'h0040_0208_8888_8888);
    check_eq("nrdy_addr2", {32'd0, imem_addr}, 64'h0040_0208);

    // PC wrap: redirect in FETCH while not accepted
    imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hffff_fffc;
    step();
    redirect_valid = 1'b0; imem_ready = 1'b1;
    check_eq("wrap_addr", {32'd0, imem_addr}, 64'hffff_fffc);
    fetch_one(32'h9999_9999);
    check_eq("wrap_if_id", if_id, 64'h0000_0000_9999_9999);
    check_eq("wrap_addr2", {32'd0, imem_addr}, 64'h0000_0000);
    check_eq("wrap_cnt8",  {48'd0, fetch_count}, 64'd8);

    // Flush in the same cycle as an accepted response
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'haaaa_aaaa; flush = 1'b1;
    step();
    imem_rvalid = 1'b0; flush = 1'b0;
    check_eq("fl_valid", {63'd0, if_id_valid}, 64'd0);
    check_eq("fl_count", {48'd0, fetch_count}, 64'd8);
    check_eq("fl_addr",  {32'd0, imem_addr}, 64'h0000_0004);

    // Reset mid-WAIT, then a late response
    step();
    rst_n = 1'b0;
    step();
    check_eq("rw_req",   {63'd0, imem_req}, 64'd0);
    check_eq("rw_addr",  {32'd0, imem_addr}, 64'h0040_0000);
    check_eq("rw_if_id", if_id, 64'd0);
    check_eq("rw_valid", {63'd0, if_id_valid}, 64'd0);
    check_eq("rw_count", {48'd0, fetch_count}, 64'd0);
    rst_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hbbbb_bbbb;
    step();
    imem_rvalid = 1'b0;
    check_eq("late_valid", {63'd0, if_id_valid}, 64'd0);
    check_eq("late_count", {48'd0, fetch_count}, 64'd0);
    check_eq("late_req",   {63'd0, imem_req}, 64'd1);
    fetch_one(32'hcccc_cccc);
    check_eq("post_if_id", if_id, 64'h0040_0004_cccc_cccc);
    check_eq("post_count", {48'd0, fetch_count}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage_pipe.md
Name: if_stage_pipe

Overview:
- Parametrised instruction-fetch stage for the 5-stage MIPS pipeline. Replaces the fixed 32-bit fetch stage.
- Owns the PC and drives a request/response instruction-memory port with at most one request outstanding.
- Loads the IF/ID pipeline register, and supports stall, flush, and branch/jump redirect, including discard of an in-flight response.
- Sits between Instruction_memory and the decode stage.

Parameters:
- XLEN, 32, datapath/PC/instruction width.
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment in bytes. Power of two.
- CNT_W, 16, width of the fetched-instruction counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  synchronous active-low reset.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  XLEN  redirect target.
- stall  in  1  decode cannot accept; hold IF/ID.
- flush  in  1  invalidate IF/ID contents (bubble).
- imem_req  out  1  request valid.
- imem_addr  out  XLEN  request address.
- imem_ready  in  1  memory accepts request this cycle.
- imem_rvalid  in  1  response valid.
- imem_rdata  in  XLEN  fetched instruction.
- if_id  out  2*XLEN  {pc+PC_STEP, instr}.
- if_id_valid  out  1  IF/ID holds a real instruction.
- fetch_count  out  CNT_W  instructions delivered to IF/ID.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - pc=RESET_PC, state=FETCH, discard=0.
  - imem_req=0, imem_addr=RESET_PC, if_id=0, if_id_valid=0, fetch_count=0, skid buffer empty.
  - imem_req first rises in the cycle after rst_n returns high.
  - Reset mid-transaction abandons the outstanding request. The memory is reset together with this block, so any late response is ignored.
- All outputs are registered. The low log2(PC_STEP) bits of redirect_pc are forced to zero.
- States:
  - FETCH:
    - imem_req=1, imem_addr=pc.
    - On imem_ready: req_pc<=pc, pc<=pc+PC_STEP (wraps mod 2^XLEN), go to WAIT.
    - Without imem_ready: hold request and address stable.
  - WAIT:
    - imem_req=0.
    - On imem_rvalid with discard=1: drop the data, clear discard, go to FETCH.
    - On imem_rvalid with discard=0 and the IF/ID register free (!if_id_valid or !stall): if_id<={req_pc+PC_STEP, imem_rdata}, if_id_valid<=1, fetch_count++, go to FETCH.
    - On imem_rvalid otherwise: capture into the skid buffer, go to HOLD.
  - HOLD:
    - imem_req=0.
    - When stall=0: skid buffer moves to IF/ID, fetch_count++, go to FETCH.
- Redirect (highest priority, any state):
  - pc<=redirect_pc.
  - In FETCH with imem_ready the same cycle: the old-address request is issued; set discard, go to WAIT.
  - In WAIT without rvalid: set discard.
  - In WAIT with rvalid: drop the response.
  - In HOLD: drop the skid buffer, go to FETCH.
  - Next request uses redirect_pc.
- Flush:
  - if_id_valid<=0 next cycle, overriding stall; if_id data unchanged.
  - Flush does not affect pc, state, or the skid buffer unless redirect_valid is also asserted.
  - A response accepted into IF/ID in the same cycle as flush is dropped and not counted.
- Stall with if_id_valid=1: if_id and if_id_valid hold.
- Stall with if_id_valid=0: IF/ID is free and may load.
- Throughput: one instruction per 2 cycles when imem_ready=1 and response latency is 1 cycle.
- fetch_count wraps modulo 2^CNT_W.
- At most one outstanding request. An imem_rvalid arriving in FETCH or HOLD is a protocol error and is ignored.

Test Plan:
- Reset with RESET_PC=0x00400000, imem_ready=1, 1-cycle response, no stall:
  - Requests issue to 0x00400000, 0x00400004, 0x00400008.
  - if_id = {0x00400004, instr0}, then {0x00400008, instr1}.
  - fetch_count=3 after third delivery.
- Stall held 3 cycles while response arrives:
  - if_id unchanged and the response is parked in the skid buffer (HOLD).
  - On release, the skid word loads next cycle. No loss, no duplication, no request during HOLD.
- Redirect to 0x00400100 while in WAIT:
  - The late response is dropped and not counted.
  - Next imem_addr=0x00400100, and if_id pc field = 0x00400104.
- Redirect in HOLD with flush:
  - if_id_valid=0 next cycle, skid buffer discarded.
  - Next fetch at the target address.
- imem_ready low 4 cycles:
  - imem_req and imem_addr stable throughout.
  - pc advances only on acceptance.
- pc=0xFFFFFFFC sequential fetch:
  - if_id pc field wraps to 0x00000000.
- rst_n low mid-WAIT:
  - All outputs return to reset values next edge; the late rvalid is ignored.
